// File: rtl/pipe_ctrl_unit.sv
// Pipeline control: prefix stall merge, exception-over-stall priority, flush/redirect FSM, stall watchdog.
// Define PIPE_CTRL_PERF_EN to build the stalled-cycle and accepted-exception counters.
module pipe_ctrl_unit #(
    parameter int               STAGES        = 6,
    parameter int               XLEN          = 32,
    parameter logic [XLEN-1:0]  INT_VEC       = 'h20,
    parameter logic [XLEN-1:0]  EXC_VEC       = 'h40,
    parameter int               FLUSH_CYCLES  = 1,
    parameter int               STALL_TIMEOUT = 1024
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [STAGES-1:0] stallreq_i,
    input  logic [31:0]       excepttype_i,
    input  logic [XLEN-1:0]   cp0_epc_i,
    output logic [STAGES-1:0] stall_o,
    output logic              flush_o,
    output logic [XLEN-1:0]   new_pc_o,
    output logic              exc_unknown_o,
    output logic              stall_timeout_o,
    output logic [31:0]       perf_stall_cnt_o,
    output logic [31:0]       perf_flush_cnt_o
);
    typedef enum logic {RUN, FLUSH} state_e;

    localparam int CW = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;

    state_e          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [XLEN-1:0] tgt_q, tgt_d;
    logic [31:0]     wd_q, wd_d;

    logic [STAGES-1:0] stall_vec;
    logic [XLEN-1:0]   exc_vec;
    logic              exc_unk;

    // Hold every stage at or below the highest requester; bit0 never requests by itself.
    always_comb begin
        logic acc;
        acc       = 1'b0;
        stall_vec = '0;
        for (int k = STAGES - 1; k >= 1; k--) begin
            acc          = acc | stallreq_i[k];
            stall_vec[k] = acc;
        end
        stall_vec[0] = acc;
    end

    always_comb begin
        exc_vec = EXC_VEC;
        exc_unk = 1'b0;
        case (excepttype_i)
            32'h01:                      exc_vec = INT_VEC;
            32'h08, 32'h0a, 32'h0c, 32'h0d: exc_vec = EXC_VEC;
            32'h0e:                      exc_vec = cp0_epc_i;
            default:                     exc_unk = (excepttype_i != 32'h0);
        endcase
    end

    always_comb begin
        state_d         = state_q;
        cnt_d           = cnt_q;
        tgt_d           = tgt_q;
        wd_d            = wd_q;
        stall_o         = '0;
        flush_o         = 1'b0;
        new_pc_o        = '0;
        exc_unknown_o   = 1'b0;
        stall_timeout_o = 1'b0;
        if (rst) begin
            state_d = RUN;
            cnt_d   = '0;
            tgt_d   = '0;
            wd_d    = '0;
        end else if (state_q == FLUSH) begin
            flush_o  = 1'b1;
            new_pc_o = tgt_q;
            wd_d     = '0;
            cnt_d    = cnt_q - CW'(1);
            if (cnt_q == CW'(1)) state_d = RUN;
        end else if (excepttype_i != 32'h0) begin
            flush_o       = 1'b1;
            new_pc_o      = exc_vec;
            exc_unknown_o = exc_unk;
            tgt_d         = exc_vec;
            wd_d          = '0;
            if (FLUSH_CYCLES > 1) begin
                state_d = FLUSH;
                cnt_d   = CW'(FLUSH_CYCLES - 1);
            end
        end else begin
            stall_o = stall_vec;
            if (stall_vec == '0) begin
                wd_d = '0;
            end else if (STALL_TIMEOUT != 0 && wd_q != 32'(STALL_TIMEOUT)) begin
                // Counter stops at the limit so the pulse fires once per stall episode.
                wd_d            = wd_q + 32'd1;
                stall_timeout_o = (wd_q == 32'(STALL_TIMEOUT - 1));
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= RUN;
            cnt_q   <= '0;
            tgt_q   <= '0;
            wd_q    <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            tgt_q   <= tgt_d;
            wd_q    <= wd_d;
        end
    end

`ifdef PIPE_CTRL_PERF_EN
    logic [31:0] stall_cnt_q, stall_cnt_d;
    logic [31:0] flush_cnt_q, flush_cnt_d;

    // Only the RUN-state acceptance counts, so a multi-cycle flush adds one.
    always_comb begin
        stall_cnt_d = stall_cnt_q + {31'b0, (stall_o != '0)};
        flush_cnt_d = flush_cnt_q + {31'b0, (state_q == RUN && excepttype_i != 32'h0)};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign perf_stall_cnt_o = stall_cnt_q;
    assign perf_flush_cnt_o = flush_cnt_q;
`else
    assign perf_stall_cnt_o = 32'h0;
    assign perf_flush_cnt_o = 32'h0;
`endif

endmodule

// File: tb/tb_pipe_ctrl_unit.sv
// Bench for pipe_ctrl_unit: two instances (FLUSH_CYCLES 1 and 3, STALL_TIMEOUT 4) driven in lockstep,
// table vectors, hand sequences for flush length / watchdog / reset, and random stimulus vs a model.
module tb_pipe_ctrl_unit;
    logic        clk;
    logic        rst;
    logic [5:0]  stallreq;
    logic [31:0] exc;
    logic [31:0] epc;

    logic [5:0]  st  [2];
    logic        fl  [2];
    logic [31:0] pc  [2];
    logic        unk [2];
    logic        to  [2];
    logic [31:0] pst [2];
    logic [31:0] pfl [2];

    pipe_ctrl_unit #(.STAGES(6), .XLEN(32), .INT_VEC(32'h20), .EXC_VEC(32'h40),
                     .FLUSH_CYCLES(1), .STALL_TIMEOUT(4)) dut1 (
        .clk(clk), .rst(rst), .stallreq_i(stallreq), .excepttype_i(exc), .cp0_epc_i(epc),
        .stall_o(st[0]), .flush_o(fl[0]), .new_pc_o(pc[0]), .exc_unknown_o(unk[0]),
        .stall_timeout_o(to[0]), .perf_stall_cnt_o(pst[0]), .perf_flush_cnt_o(pfl[0]));

    pipe_ctrl_unit #(.STAGES(6), .XLEN(32), .INT_VEC(32'h20), .EXC_VEC(32'h40),
                     .FLUSH_CYCLES(3), .STALL_TIMEOUT(4)) dut3 (
        .clk(clk), .rst(rst), .stallreq_i(stallreq), .excepttype_i(exc), .cp0_epc_i(epc),
        .stall_o(st[1]), .flush_o(fl[1]), .new_pc_o(pc[1]), .exc_unknown_o(unk[1]),
        .stall_timeout_o(to[1]), .perf_stall_cnt_o(pst[1]), .perf_flush_cnt_o(pfl[1]));

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int n_vec = 0;
    int n_err = 0;

    // Reference model state: remaining flush cycles, redirect target, stall run length, perf totals.
    int          m_rem  [2];
    logic [31:0] m_tgt  [2];
    int          m_run  [2];
    logic [31:0] m_pst  [2];
    logic [31:0] m_pfl  [2];
    bit          m_init = 1'b0;

    // Last sampled outputs, for the hand-written sequences.
    logic        o_fl  [2];
    logic [31:0] o_pc  [2];
    logic        o_to  [2];
    logic        o_unk [2];
    logic [5:0]  o_st  [2];
    logic [31:0] o_pst [2];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, want %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] mvec(input logic [31:0] code, input logic [31:0] e, output logic u);
        u = 1'b0;
        if (code == 32'h01) return 32'h20;
        if (code == 32'h0e) return e;
        if (!(code inside {32'h08, 32'h0a, 32'h0c, 32'h0d})) u = 1'b1;
        return 32'h40;
    endfunction

    task automatic apply(input logic r, input logic [5:0] sr, input logic [31:0] ex, input logic [31:0] ep);
        logic [5:0]  e_st;
        logic        e_fl, e_unk, e_to, u;
        logic [31:0] e_pc, v;
        int          k;
        rst = r; stallreq = sr; exc = ex; epc = ep;
        #4;
        for (int i = 0; i < 2; i++) begin
            e_st = '0; e_fl = 1'b0; e_pc = '0; e_unk = 1'b0; e_to = 1'b0;
            if (r) begin
            end else if (m_rem[i] > 0) begin
                e_fl = 1'b1; e_pc = m_tgt[i];
            end else if (ex != 0) begin
                e_fl = 1'b1; e_pc = mvec(ex, ep, u); e_unk = u;
            end else begin
                k = -1;
                for (int j = 1; j < 6; j++) if (sr[j]) k = j;
                if (k >= 0) begin
                    e_st = 6'((1 << (k + 1)) - 1);
                    e_to = (m_run[i] + 1 == 4);
                end
            end
            chk($sformatf("stall[%0d]", i), 32'(st[i]), 32'(e_st));
            chk($sformatf("flush[%0d]", i), 32'(fl[i]), 32'(e_fl));
            chk($sformatf("new_pc[%0d]", i), pc[i], e_pc);
            chk($sformatf("exc_unknown[%0d]", i), 32'(unk[i]), 32'(e_unk));
            chk($sformatf("stall_timeout[%0d]", i), 32'(to[i]), 32'(e_to));
            if (!r && m_init) begin
`ifdef PIPE_CTRL_PERF_EN
                chk($sformatf("perf_stall[%0d]", i), pst[i], m_pst[i]);
                chk($sformatf("perf_flush[%0d]", i), pfl[i], m_pfl[i]);
`else
                chk($sformatf("perf_stall[%0d]", i), pst[i], 32'h0);
                chk($sformatf("perf_flush[%0d]", i), pfl[i], 32'h0);
`endif
            end
            o_fl[i] = fl[i]; o_pc[i] = pc[i]; o_to[i] = to[i];
            o_unk[i] = unk[i]; o_st[i] = st[i]; o_pst[i] = pst[i];
        end
        @(posedge clk);
        for (int i = 0; i < 2; i++) begin
            if (r) begin
                m_rem[i] = 0; m_tgt[i] = '0; m_run[i] = 0; m_pst[i] = '0; m_pfl[i] = '0;
                m_init = 1'b1;
            end else if (m_rem[i] > 0) begin
                m_rem[i]--; m_run[i] = 0;
            end else if (ex != 0) begin
                v = mvec(ex, ep, u);
                m_tgt[i] = v; m_rem[i] = (i == 0) ? 0 : 2; m_pfl[i]++; m_run[i] = 0;
            end else if (sr[5:1] != 0) begin
                m_run[i]++; m_pst[i]++;
            end else begin
                m_run[i] = 0;
            end
        end
        #1;
    endtask

    typedef struct {
        logic        r;
        logic [5:0]  sr;
        logic [31:0] ex;
        logic [31:0] ep;
        logic [5:0]  e_st;
        logic        e_fl;
        logic [31:0] e_pc;
        logic        e_unk;
    } vec_t;

    vec_t tbl [16];

    initial begin
        int pulses, pulse_at, flush_len;
        logic [31:0] code;
        logic [31:0] codes [7];

        tbl[0]  = '{1'b1, 6'b111111, 32'h01, 32'h5,        6'b000000, 1'b0, 32'h0,        1'b0};
        tbl[1]  = '{1'b1, 6'b010101, 32'h0e, 32'h99,       6'b000000, 1'b0, 32'h0,        1'b0};
        tbl[2]  = '{1'b0, 6'b000000, 32'h00, 32'h0,        6'b000000, 1'b0, 32'h0,        1'b0};
        tbl[3]  = '{1'b0, 6'b000100, 32'h00, 32'h0,        6'b000111, 1'b0, 32'h0,        1'b0};
        tbl[4]  = '{1'b0, 6'b001000, 32'h00, 32'h0,        6'b001111, 1'b0, 32'h0,        1'b0};
        tbl[5]  = '{1'b0, 6'b001100, 32'h00, 32'h0,        6'b001111, 1'b0, 32'h0,        1'b0};
        tbl[6]  = '{1'b0, 6'b000001, 32'h00, 32'h0,        6'b000000, 1'b0, 32'h0,        1'b0};
        tbl[7]  = '{1'b0, 6'b001000, 32'h01, 32'h0,        6'b000000, 1'b1, 32'h20,       1'b0};
        tbl[8]  = '{1'b0, 6'b000000, 32'h00, 32'h0,        6'b000000, 1'b0, 32'h0,        1'b0};
        tbl[9]  = '{1'b0, 6'b000000, 32'h05, 32'h0,        6'b000000, 1'b1, 32'h40,       1'b1};
        tbl[10] = '{1'b0, 6'b100000, 32'h0e, 32'hcafe0000, 6'b000000, 1'b1, 32'hcafe0000, 1'b0};
        tbl[11] = '{1'b0, 6'b100000, 32'h00, 32'h0,        6'b111111, 1'b0, 32'h0,        1'b0};
        tbl[12] = '{1'b0, 6'b000010, 32'h0a, 32'h0,        6'b000000, 1'b1, 32'h40,       1'b0};
        tbl[13] = '{1'b0, 6'b000000, 32'h0c, 32'h0,        6'b000000, 1'b1, 32'h40,       1'b0};
        tbl[14] = '{1'b0, 6'b000000, 32'h0d, 32'h0,        6'b000000, 1'b1, 32'h40,       1'b0};
        tbl[15] = '{1'b0, 6'b000000, 32'h08, 32'hffff,     6'b000000, 1'b1, 32'h40,       1'b0};

        rst = 1'b1; stallreq = '0; exc = '0; epc = '0;

        // Watchdog: 10 held cycles give one pulse on the 4th, a 1-cycle gap re-arms it.
        apply(1'b1, 6'($urandom), $urandom, $urandom);
        apply(1'b1, 6'($urandom), $urandom, $urandom);
        pulses = 0; pulse_at = -1;
        for (int c = 1; c <= 10; c++) begin
            apply(1'b0, 6'b000100, 32'h0, 32'h0);
            if (o_to[0]) begin pulses++; if (pulse_at < 0) pulse_at = c; end
        end
        chk("wd_first_pulses", 32'(pulses), 32'd1);
        chk("wd_first_cycle", 32'(pulse_at), 32'd4);
        apply(1'b0, 6'b000000, 32'h0, 32'h0);
        for (int c = 1; c <= 4; c++) begin
            apply(1'b0, 6'b000100, 32'h0, 32'h0);
            if (o_to[0]) pulses++;
        end
        chk("wd_second_pulses", 32'(pulses), 32'd2);
        apply(1'b0, 6'b000000, 32'h0, 32'h0);
`ifdef PIPE_CTRL_PERF_EN
        chk("perf_stall_14", o_pst[0], 32'd14);
`else
        chk("perf_stall_off", o_pst[0], 32'd0);
`endif

        // Table vectors, checked against the FLUSH_CYCLES=1 instance.
        for (int t = 0; t < 16; t++) begin
            apply(tbl[t].r, tbl[t].sr, tbl[t].ex, tbl[t].ep);
            chk($sformatf("tbl%0d_stall", t), 32'(o_st[0]), 32'(tbl[t].e_st));
            chk($sformatf("tbl%0d_flush", t), 32'(o_fl[0]), 32'(tbl[t].e_fl));
            chk($sformatf("tbl%0d_pc", t), o_pc[0], tbl[t].e_pc);
            chk($sformatf("tbl%0d_unk", t), 32'(o_unk[0]), 32'(tbl[t].e_unk));
        end

        // FLUSH_CYCLES=3: eret target held for 3 cycles, second code ignored.
        apply(1'b0, 6'b000000, 32'h0, 32'h0);
        flush_len = 0;
        apply(1'b0, 6'b000000, 32'h0e, 32'h1234);
        if (o_fl[1]) flush_len++;
        chk("eret_pc0", o_pc[1], 32'h1234);
        apply(1'b0, 6'b001000, 32'h08, 32'h5678);
        if (o_fl[1]) flush_len++;
        chk("eret_pc1", o_pc[1], 32'h1234);
        apply(1'b0, 6'b000000, 32'h0, 32'h5678);
        if (o_fl[1]) flush_len++;
        chk("eret_pc2", o_pc[1], 32'h1234);
        apply(1'b0, 6'b000000, 32'h0, 32'h0);
        if (o_fl[1]) flush_len++;
        chk("eret_flush_len", 32'(flush_len), 32'd3);

        // Reset in the middle of a flush.
        apply(1'b0, 6'b000000, 32'h01, 32'h0);
        apply(1'b1, 6'b000000, 32'h0, 32'h0);
        apply(1'b0, 6'b000000, 32'h0, 32'h0);
        chk("rst_mid_flush", 32'(o_fl[1]), 32'd0);
        chk("rst_mid_pc", o_pc[1], 32'h0);

        codes = '{32'h01, 32'h08, 32'h0a, 32'h0c, 32'h0d, 32'h0e, 32'h0};
        for (int n = 0; n < 600; n++) begin
            code = 32'h0;
            if ($urandom_range(3) == 0) begin
                code = codes[$urandom_range(6)];
                if (code == 32'h0) code = $urandom | 32'h1;
            end
            apply(($urandom_range(60) == 0), 6'($urandom), code, $urandom);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
